// File: rtl/read_stage_rr_arbiter.sv
// Two-input round-robin arbiter in front of a VRF read port.
// A single lastGrant bit steers contention; everything else is a combinational mux.
module read_stage_rr_arbiter (
  input  logic       clock,
  input  logic       reset,
  input  logic       io_in_0_valid,
  output logic       io_in_0_ready,
  input  logic [4:0] io_in_0_bits_vs,
  input  logic [2:0] io_in_0_bits_offset,
  input  logic [3:0] io_in_0_bits_groupIndex,
  input  logic [3:0] io_in_0_bits_readSource,
  input  logic [2:0] io_in_0_bits_instructionIndex,
  input  logic       io_in_1_valid,
  output logic       io_in_1_ready,
  input  logic [4:0] io_in_1_bits_vs,
  input  logic [2:0] io_in_1_bits_offset,
  input  logic [3:0] io_in_1_bits_groupIndex,
  input  logic [3:0] io_in_1_bits_readSource,
  input  logic [2:0] io_in_1_bits_instructionIndex,
  input  logic       io_out_ready,
  output logic       io_out_valid,
  output logic [4:0] io_out_bits_vs,
  output logic [2:0] io_out_bits_offset,
  output logic [3:0] io_out_bits_readSource,
  output logic [2:0] io_out_bits_instructionIndex
);

  logic last_grant_q;
  logic last_grant_d;
  logic chosen;
  logic fire;

  // groupIndex is carried on the request bundle but not needed downstream.
  logic unused_group;
  assign unused_group = ^{io_in_0_bits_groupIndex, io_in_1_bits_groupIndex};

  // With no valid input, index 1 is chosen so the idle output mirrors input 1.
  always_comb begin
    chosen = 1'b1;
    if (io_in_0_valid && io_in_1_valid) begin
      chosen = ~last_grant_q;
    end else if (io_in_0_valid) begin
      chosen = 1'b0;
    end
  end

  assign io_out_valid  = io_in_0_valid | io_in_1_valid;
  assign fire          = io_out_valid & io_out_ready;
  assign io_in_0_ready = io_out_ready & ~chosen;
  assign io_in_1_ready = io_out_ready & chosen;

  assign io_out_bits_vs               = chosen ? io_in_1_bits_vs               : io_in_0_bits_vs;
  assign io_out_bits_offset           = chosen ? io_in_1_bits_offset           : io_in_0_bits_offset;
  assign io_out_bits_readSource       = chosen ? io_in_1_bits_readSource       : io_in_0_bits_readSource;
  assign io_out_bits_instructionIndex = chosen ? io_in_1_bits_instructionIndex : io_in_0_bits_instructionIndex;

  assign last_grant_d = fire ? chosen : last_grant_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_read_stage_rr_arbiter.sv
// Bench for read_stage_rr_arbiter: directed scenarios then random traffic,
// checked against a round-robin reference model that tracks the last grant.
module tb_read_stage_rr_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       in0_valid, in1_valid, out_ready;
  logic       in0_ready, in1_ready, out_valid;
  logic [4:0] in0_vs, in1_vs, out_vs;
  logic [2:0] in0_off, in1_off, out_off;
  logic [3:0] in0_grp, in1_grp;
  logic [3:0] in0_rs, in1_rs, out_rs;
  logic [2:0] in0_ii, in1_ii, out_ii;

  int n_checks = 0;
  int n_fail   = 0;
  int model_lg = 1;

  always #5 clock = ~clock;

  read_stage_rr_arbiter dut (
    .clock                         (clock),
    .reset                         (reset),
    .io_in_0_valid                 (in0_valid),
    .io_in_0_ready                 (in0_ready),
    .io_in_0_bits_vs               (in0_vs),
    .io_in_0_bits_offset           (in0_off),
    .io_in_0_bits_groupIndex       (in0_grp),
    .io_in_0_bits_readSource       (in0_rs),
    .io_in_0_bits_instructionIndex (in0_ii),
    .io_in_1_valid                 (in1_valid),
    .io_in_1_ready                 (in1_ready),
    .io_in_1_bits_vs               (in1_vs),
    .io_in_1_bits_offset           (in1_off),
    .io_in_1_bits_groupIndex       (in1_grp),
    .io_in_1_bits_readSource       (in1_rs),
    .io_in_1_bits_instructionIndex (in1_ii),
    .io_out_ready                  (out_ready),
    .io_out_valid                  (out_valid),
    .io_out_bits_vs                (out_vs),
    .io_out_bits_offset            (out_off),
    .io_out_bits_readSource        (out_rs),
    .io_out_bits_instructionIndex  (out_ii)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Round robin: search upward from the slot after the last grant; idle picks 1.
  function automatic int ref_grant(input int lg, input logic v0, input logic v1);
    logic [1:0] v;
    v = {v1, v0};
    for (int k = 1; k <= 2; k++) begin
      if (v[(lg + k) % 2]) return (lg + k) % 2;
    end
    return 1;
  endfunction

  task automatic drive(input logic v0, input logic v1, input logic rdy, input logic rst);
    @(negedge clock);
    in0_valid = v0;   in1_valid = v1;   out_ready = rdy; reset = rst;
    in0_vs  = 5'($urandom); in1_vs  = 5'($urandom);
    in0_off = 3'($urandom); in1_off = 3'($urandom);
    in0_grp = 4'($urandom); in1_grp = 4'($urandom);
    in0_rs  = 4'($urandom); in1_rs  = 4'($urandom);
    in0_ii  = 3'($urandom); in1_ii  = 3'($urandom);
  endtask

  // Check all outputs against the model, then clock and advance the model.
  task automatic step(input logic do_chk, output int grant);
    int g;
    int fire;
    #1;
    g = ref_grant(model_lg, in0_valid, in1_valid);
    fire = (in0_valid || in1_valid) && out_ready;
    if (do_chk) begin
      chk("out_valid", 32'(out_valid), 32'(in0_valid | in1_valid));
      chk("in0_ready", 32'(in0_ready), 32'(out_ready && g == 0));
      chk("in1_ready", 32'(in1_ready), 32'(out_ready && g == 1));
      chk("out_vs",  32'(out_vs),  32'(g == 1 ? in1_vs  : in0_vs));
      chk("out_off", 32'(out_off), 32'(g == 1 ? in1_off : in0_off));
      chk("out_rs",  32'(out_rs),  32'(g == 1 ? in1_rs  : in0_rs));
      chk("out_ii",  32'(out_ii),  32'(g == 1 ? in1_ii  : in0_ii));
    end
    grant = g;
    @(posedge clock);
    if (reset) model_lg = 1;
    else if (fire) model_lg = g;
  endtask

  int g;
  int exp_seq [4] = '{0, 1, 0, 1};

  initial begin
    in0_valid = 0; in1_valid = 0; out_ready = 0; reset = 1;
    drive(0, 0, 0, 1); step(0, g);
    drive(0, 0, 1, 1); step(1, g);

    // in0 alone with fixed fields
    drive(1, 0, 1, 0);
    in0_vs = 5'd5; in0_off = 3'd2; in0_rs = 4'hA; in0_ii = 3'd3;
    #1;
    chk("s1_valid", 32'(out_valid), 32'd1);
    chk("s1_vs",    32'(out_vs),    32'd5);
    chk("s1_off",   32'(out_off),   32'd2);
    chk("s1_rs",    32'(out_rs),    32'hA);
    chk("s1_ii",    32'(out_ii),    32'd3);
    chk("s1_rdy0",  32'(in0_ready), 32'd1);
    chk("s1_rdy1",  32'(in1_ready), 32'd0);
    step(1, g);

    // both valid after reset: strict alternation starting at input 0
    drive(0, 0, 0, 1); step(1, g);
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 1, 0);
      #1 chk("s2_grant", 32'(in1_ready), 32'(exp_seq[i]));
      step(1, g);
    end

    // stall: lastGrant is 1 here, so the grant after the stall is input 0
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0);
      #1 chk("s3_stall_rdy", 32'({in0_ready, in1_ready}), 32'd0);
      step(1, g);
    end
    drive(1, 1, 1, 0);
    #1 chk("s3_after_stall", 32'({in1_ready, in0_ready}), 32'b01);
    step(1, g);

    // in1 alone fires, then contention goes to input 0
    drive(0, 1, 1, 0); step(1, g);
    drive(1, 1, 1, 0);
    #1 chk("s4_grant0", 32'(in0_ready), 32'd1);
    step(1, g);

    // reset with lastGrant=0 during contention
    drive(1, 0, 1, 0); step(1, g);
    drive(1, 1, 1, 1); step(1, g);
    drive(1, 1, 1, 0);
    #1 chk("s5_grant0", 32'(in0_ready), 32'd1);
    step(1, g);

    // reset must beat a same-cycle fire that would load 0
    drive(0, 1, 1, 0); step(1, g);
    drive(1, 1, 1, 1); step(1, g);
    drive(1, 1, 1, 0);
    #1 chk("s5b_grant0", 32'(in0_ready), 32'd1);
    step(1, g);

    // idle: out_valid low, in1_ready follows out_ready
    for (int r = 0; r < 2; r++) begin
      drive(0, 0, 1'(r), 0);
      #1;
      chk("s6_valid", 32'(out_valid), 32'd0);
      chk("s6_rdy0",  32'(in0_ready), 32'd0);
      chk("s6_rdy1",  32'(in1_ready), 32'(r));
      step(1, g);
    end

    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 19) == 0));
      step(1, g);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/read_stage_rr_arbiter.md
READ_STAGE_RR_ARBITER -- requirements
Module: read_stage_rr_arbiter

Interface
REQ-001 The block SHALL have no parameters; all widths below are fixed.
REQ-002 The block SHALL have these ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- io_in_0_valid  in  1  request valid, port 0.
- io_in_0_ready  out  1  request accepted, port 0.
- io_in_0_bits_vs  in  5  vector register index, port 0.
- io_in_0_bits_offset  in  3  register offset, port 0.
- io_in_0_bits_groupIndex  in  4  group index, port 0; not forwarded.
- io_in_0_bits_readSource  in  4  read-source tag, port 0.
- io_in_0_bits_instructionIndex  in  3  instruction tag, port 0.
- io_in_1_valid, io_in_1_ready, io_in_1_bits_vs, io_in_1_bits_offset, io_in_1_bits_groupIndex, io_in_1_bits_readSource, io_in_1_bits_instructionIndex  port 1, same directions, widths and meanings as port 0.
- io_out_ready  in  1  downstream (VRF read port) accepts.
- io_out_valid  out  1  granted request present.
- io_out_bits_vs  out  5  vs of the granted input.
- io_out_bits_offset  out  3  offset of the granted input.
- io_out_bits_readSource  out  4  readSource of the granted input.
- io_out_bits_instructionIndex  out  3  instructionIndex of the granted input.

Function
REQ-003 State SHALL be a single 1-bit register lastGrant, the index of the input granted at the most recent output fire.
REQ-004 io_out_valid SHALL equal io_in_0_valid OR io_in_1_valid, combinationally and with 0-cycle latency.
REQ-005 Grant selection SHALL be combinational:
- Only one input valid: that input is granted.
- Both valid, lastGrant=0: input 1 is granted.
- Both valid, lastGrant=1: input 0 is granted.
REQ-006 When neither input is valid, the chosen index SHALL be 1 and io_out_bits SHALL reflect input 1's fields; io_out_valid SHALL be 0.
REQ-007 io_out_bits_* SHALL be a pure mux of the chosen input's vs, offset, readSource and instructionIndex; groupIndex SHALL be ignored.
REQ-008 io_in_i_ready SHALL equal io_out_ready AND (chosen index == i), with no dependence on io_in_i_valid; the non-chosen input's ready SHALL be 0.
REQ-009 Output fire SHALL be io_out_valid AND io_out_ready.
REQ-010 On fire, lastGrant SHALL load the chosen index at the next rising edge; otherwise it SHALL hold.
REQ-011 While io_out_ready is 0, lastGrant SHALL hold, and the granted input SHALL NOT change unless the input valids change.
REQ-012 At most one input SHALL be accepted per cycle; no request is buffered, dropped or duplicated by the block.
REQ-013 Combinational paths SHALL exist only from inputs to outputs; there SHALL be no combinational loop through io_out_ready.

Reset
REQ-014 When reset is high at a rising edge, lastGrant SHALL become 1, so input 0 has priority on the first contention after reset.
REQ-015 The reset value of every output SHALL be its combinational value with lastGrant=1; outputs are not forced to 0 during reset.
REQ-016 Reset asserted mid-operation SHALL override any same-cycle fire update of lastGrant.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- After reset, in0 valid (vs=5, offset=2, readSource=4'hA, instIdx=3), in1 invalid, out_ready=1 -> out_valid=1, bits equal in0's, in0_ready=1, in1_ready=0.
- After reset, both inputs valid, out_ready=1 for 4 cycles -> grants 0,1,0,1; out bits track the granted input each cycle.
- Both inputs valid, out_ready=0 for 3 cycles, then 1 -> in0_ready=in1_ready=0 while stalled, lastGrant unchanged; first grant after the stall follows the pre-stall lastGrant.
- in1 alone fires (lastGrant becomes 1), then both valid -> input 0 granted.
- Both valid with lastGrant=0, reset pulsed for 1 cycle -> next cycle input 0 granted.
- No input valid -> out_valid=0, in0_ready=0, in1_ready=out_ready.
